// File: rtl/serial_pkg.sv
// serial_pkg: shared width default, state enum and length-field width helper
package serial_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic {IDLE, SHIFT} state_e;
  function automatic int len_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: serialises operand pairs LSB-first for a serial adder
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [len_w(WIDTH)-1:0]  in_len,
  input  logic                     pause,
  output logic                     vld,
  output logic                     a,
  output logic                     b,
  output logic                     last
);
  localparam int LW = len_w(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  // outputs are pure decodes of the held word so a new word can chain on last
  always_comb begin
    vld    = (state_q == SHIFT) && !pause;
    last   = vld && (cnt_q == LW'(1));
    in_rdy = (state_q == IDLE) || last;
    a      = sa_q[0];
    b      = sb_q[0];
  end
  // load on handshake, shift on each emitted pair, clear when the word drains
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    if (in_vld && in_rdy) begin
      state_d = SHIFT;
      sa_d    = in_a;
      sb_d    = in_b;
      cnt_d   = (in_len == '0) ? LW'(WIDTH) : in_len;
    end else if (vld) begin
      state_d = last ? IDLE : SHIFT;
      sa_d    = last ? '0 : sa_q >> 1;
      sb_d    = last ? '0 : sb_q >> 1;
      cnt_d   = cnt_q - LW'(1);
    end
  end
  // state register; reset discards any in-flight word immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb_serial_operand_feeder: directed checks of the serial operand feeder
module tb_serial_operand_feeder;
  logic       clk = 0;
  logic       rst_n, in_vld, in_rdy, pause, vld, a, b, last;
  logic [7:0] in_a, in_b;
  logic [3:0] in_len;
  int         total = 0, bad = 0, nlast = 0;
  logic       cy;
  logic [7:0] sum;
  serial_operand_feeder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_a(in_a), .in_b(in_b), .in_len(in_len), .pause(pause),
    .vld(vld), .a(a), .b(b), .last(last)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (last) nlast++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [7:0] wa, input logic [7:0] wb, input logic [3:0] wl);
    in_a = wa; in_b = wb; in_len = wl; in_vld = 1;
    #1 chk("offer_rdy", in_rdy, 1);
    tick();
    in_vld = 0;
  endtask
  task automatic pairs(input string tag, input logic [7:0] wa, input logic [7:0] wb, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_vld"}, vld, 1);
      chk({tag, "_a"}, a, wa[i]);
      chk({tag, "_b"}, b, wb[i]);
      chk({tag, "_last"}, last, i == n - 1);
      tick();
    end
  endtask
  initial begin
    logic [7:0] wa, wb, wa2, wb2;
    int p;
    rst_n = 0; in_vld = 0; in_a = 0; in_b = 0; in_len = 0; pause = 1;
    #2;
    chk("rst_rdy", in_rdy, 1);
    chk("rst_vld", vld, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_last", last, 0);
    pause = 0;
    tick();
    rst_n = 1;
    // single full-width word feeding a serial adder model
    offer(8'h05, 8'h03, 4'd0);
    cy = 0; sum = 0; wa = 8'h05; wb = 8'h03;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("w1_vld", vld, 1);
      chk("w1_a", a, wa[i]);
      chk("w1_b", b, wb[i]);
      chk("w1_last", last, i == 7);
      sum[i] = a ^ b ^ cy;
      cy = (a & b) | (a & cy) | (b & cy);
      tick();
    end
    chk("w1_sum", sum, 8'h08);
    chk("w1_idle_vld", vld, 0);
    chk("w1_idle_rdy", in_rdy, 1);
    // back-to-back words with in_vld held
    wa = 8'h5A; wb = 8'h0F; wa2 = 8'h3C; wb2 = 8'h81;
    in_a = wa; in_b = wb; in_len = 0; in_vld = 1;
    tick();
    in_a = wa2; in_b = wb2;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("b2b_vld", vld, 1);
      chk("b2b_a", a, i < 8 ? wa[i % 8] : wa2[i % 8]);
      chk("b2b_b", b, i < 8 ? wb[i % 8] : wb2[i % 8]);
      chk("b2b_last", last, i == 7 || i == 15);
      chk("b2b_rdy", in_rdy, i == 7 || i == 15 ? 1'b1 : (in_vld ? 1'b0 : 1'b0));
      tick();
      if (i == 7) in_vld = 0;
    end
    chk("b2b_idle", vld, 0);
    // short word: only in_len bits leave
    offer(8'hFF, 8'h01, 4'd3);
    pairs("len3", 8'hFF, 8'h01, 3);
    chk("len3_idle_vld", vld, 0);
    chk("len3_idle_rdy", in_rdy, 1);
    // pause during pairs 3-4 holds everything
    wa = 8'hB4; wb = 8'h6D;
    offer(wa, wb, 4'd0);
    p = 0;
    for (int c = 0; c < 10; c++) begin
      pause = (c == 2 || c == 3);
      #1;
      if (pause) begin
        chk("pz_vld", vld, 0);
        chk("pz_last", last, 0);
        chk("pz_rdy", in_rdy, 0);
        chk("pz_a", a, wa[p]);
        chk("pz_b", b, wb[p]);
      end else begin
        chk("pz_run_vld", vld, 1);
        chk("pz_run_a", a, wa[p]);
        chk("pz_run_b", b, wb[p]);
        chk("pz_run_last", last, p == 7);
        chk("pz_run_rdy", in_rdy, p == 7);
        p++;
      end
      tick();
    end
    pause = 0;
    chk("pz_idle", vld, 0);
    // reset during pair 4 discards the word
    offer(8'hC3, 8'h99, 4'd0);
    pairs("pre", 8'hC3, 8'h99, 0);
    for (int i = 0; i < 3; i++) tick();
    #1 chk("mid_vld", vld, 1);
    rst_n = 0;
    #1;
    chk("arst_vld", vld, 0);
    chk("arst_last", last, 0);
    chk("arst_rdy", in_rdy, 1);
    chk("arst_a", a, 0);
    tick();
    rst_n = 1;
    // new word after reset starts at bit 0; a mid-word offer is ignored
    wa = 8'h96; wb = 8'h0A;
    offer(wa, wb, 4'd4);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        in_a = 8'hFF; in_b = 8'hFF; in_len = 4'd1; in_vld = 1;
      end
      #1;
      if (i == 1) chk("busy_rdy", in_rdy, 0);
      chk("post_vld", vld, 1);
      chk("post_a", a, wa[i]);
      chk("post_b", b, wb[i]);
      chk("post_last", last, i == 3);
      tick();
      in_vld = 0;
    end
    chk("post_idle", vld, 0);
    tick();
    chk("last_count", nlast, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_operand_feeder.md
SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel operand width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_vld  input  1  parallel operand word offered.
REQ-006 in_rdy  output  1  block accepts the offered word this cycle.
REQ-007 in_a  input  WIDTH  first operand, LSB sent first.
REQ-008 in_b  input  WIDTH  second operand, LSB sent first.
REQ-009 in_len  input  $clog2(WIDTH+1)  number of bits to send; 0 means WIDTH.
REQ-010 pause  input  1  downstream gap request; suppresses emission this cycle.
REQ-011 vld  output  1  serial bit pair valid, drives a serial adder's vld.
REQ-012 a  output  1  current bit of in_a.
REQ-013 b  output  1  current bit of in_b.
REQ-014 last  output  1  current pair is the word's final (MSB-side) pair; high only while vld is high.

Function
REQ-015 Word handshake SHALL be in_vld && in_rdy at a rising clk edge; the word, including in_len, SHALL be captured into shift registers at that edge.
REQ-016 States SHALL be IDLE (no word held) and SHIFT (word held, remaining count cnt >= 1).
REQ-017 in_rdy SHALL be combinational: high in IDLE, or in SHIFT when vld && last; low otherwise.
REQ-018 In SHIFT, vld SHALL equal !pause; in IDLE, vld SHALL be 0.
REQ-019 a and b SHALL equal bit 0 of the respective shift register; last SHALL equal vld && (cnt == 1).
REQ-020 On each edge where vld is high, both shift registers SHALL shift right by one and cnt SHALL decrement by one.
REQ-021 When pause is high in SHIFT, shift registers and cnt SHALL hold; the a/b values SHALL remain stable.
REQ-022 Latency: the first pair of an accepted word SHALL appear (vld high, absent pause) in the cycle immediately after the handshake edge.
REQ-023 On the edge where the last pair is sent: if a handshake occurs, the new word SHALL load and SHIFT continues with zero idle cycles; otherwise the state SHALL go to IDLE.
REQ-024 Bits of in_a/in_b at positions >= effective length SHALL never be emitted.
REQ-025 in_vld with in_rdy low SHALL not alter state; the offering side holds the word.
REQ-026 Exactly one last SHALL be emitted per accepted word, on its final pair.

Reset
REQ-027 While rst_n is low, state SHALL be IDLE, cnt and shift registers SHALL be 0, vld/a/b/last SHALL be 0 and in_rdy SHALL be 1.
REQ-028 Assertion of rst_n mid-word SHALL discard the word immediately (asynchronously) with no last emitted.
REQ-029 After rst_n rises, the first handshake SHALL start a word from bit 0.

Structure
REQ-030 A shared package serial_pkg SHALL hold the default WIDTH constant, the state enum (IDLE, SHIFT) and the length-field width function.
REQ-031 No sub-module is required; the block SHALL be a single module.

Verification
REQ-032 WIDTH=8, in_a=0x05, in_b=0x03, in_len=0 -> 8 consecutive vld cycles, a=1,0,1,0,0,0,0,0, b=1,1,0,0,0,0,0,0, last on cycle 8; downstream serial adder sum bits = 0x08.
REQ-033 Two words offered back-to-back (in_vld held) -> second accepted on first word's last cycle, 16 contiguous vld cycles, last on cycles 8 and 16.
REQ-034 in_a=0xFF, in_b=0x01, in_len=3 -> 3 vld cycles, a=1,1,1, b=1,0,0, last on cycle 3, then IDLE with in_rdy=1.
REQ-035 pause high during pairs 3-4 of an 8-bit word -> vld low 2 cycles, a/b held, last still on the 8th valid pair, in_rdy low throughout.
REQ-036 rst_n pulsed low during pair 4 -> vld and last drop at once, no last seen for that word, next word after release emits from its bit 0.
REQ-037 in_vld high while SHIFT and not on last -> in_rdy=0, word not captured, shift sequence of the current word unchanged.
